// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver state encoding and small
// helpers used by both the transmitter and receiver.
package uart_pkg;

    localparam int PARITY_ODD   = 1;
    localparam int PARITY_MARK  = 2;
    localparam int PARITY_SPACE = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Parity bit the line must carry for a character; unused upper bits must be 0.
    function automatic logic parity_expected(input int ptype, input logic [8:0] data);
        logic p;
        case (ptype)
            PARITY_ODD:   p = ~^data;
            PARITY_MARK:  p = 1'b1;
            PARITY_SPACE: p = 1'b0;
            default:      p = ^data;
        endcase
        return p;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line with a registered previous value,
// reset to the idle (high) level so reset release never looks like a start edge.
module uart_rx_sync (
    input  logic aclk,
    input  logic arst,
    input  logic rxd,
    output logic rxd_s,
    output logic fall
);

    logic meta;
    logic rxd_prev;

    always_ff @(posedge aclk) begin
        if (arst) begin
            meta     <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            meta     <= rxd;
            rxd_s    <= meta;
            rxd_prev <= rxd_s;
        end
    end

    assign fall = rxd_prev & ~rxd_s;

endmodule

// File: rtl/axis_uart_rx.sv
// Oversampling UART receiver with a one-character AXI-Stream output buffer;
// parity and framing errors travel with the character in tuser.
module axis_uart_rx
    import uart_pkg::*;
#(
    parameter int PARITY_ENA  = 0,
    parameter int PARITY_TYPE = 1,
    parameter int STOP_BITS   = 1,
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 aclk,
    input  logic                 arst,
    input  logic                 rxd,
    input  logic                 uart_ena,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [1:0]           m_axis_tuser,
    output logic                 overrun
);

    localparam int TICK_W = clog2(OVERSAMPLE);
    localparam int BIT_W  = clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

    rx_state_t            state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_err;
    logic                 frame_err;
    logic                 rxd_s;
    logic                 fall;
    logic                 sample;

    uart_rx_sync u_sync (
        .aclk  (aclk),
        .arst  (arst),
        .rxd   (rxd),
        .rxd_s (rxd_s),
        .fall  (fall)
    );

    // The start bit is checked at its middle; every later bit one full bit period on.
    assign sample = uart_ena && (tick_cnt == ((state == START) ? MID_TICK : LAST_TICK));

    always_ff @(posedge aclk) begin
        // NOTE: every register, the shift register included, is cleared by reset so a
        // mid-frame reset leaves no partial or buffered character behind.
        if (arst) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            stop_cnt      <= 1'b0;
            shreg         <= '0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= '0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (state != IDLE && uart_ena) begin
                tick_cnt <= sample ? '0 : tick_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        tick_cnt   <= '0;
                        bit_cnt    <= '0;
                        stop_cnt   <= 1'b0;
                        parity_err <= 1'b0;
                        frame_err  <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (sample) begin
                        state <= rxd_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_ENA != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (sample) begin
                        parity_err <= (rxd_s != parity_expected(PARITY_TYPE, 9'(shreg)));
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (sample) begin
                        if (stop_cnt == LAST_STOP) begin
                            stop_cnt <= 1'b0;
                            state    <= IDLE;
                            // A full buffer that is not being drained loses the new frame.
                            if (!m_axis_tvalid || m_axis_tready) begin
                                m_axis_tvalid <= 1'b1;
                                m_axis_tdata  <= shreg;
                                m_axis_tuser  <= {frame_err | ~rxd_s, parity_err};
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= frame_err | ~rxd_s;
                            stop_cnt  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_uart_rx.sv
// Directed and randomized bench for axis_uart_rx: three receiver configurations driven
// by a behavioural serial transmitter, outputs compared against a frame-level model.
module tb_axis_uart_rx;

    logic       aclk = 1'b0;
    logic       arst = 1'b1;
    logic       uart_ena = 1'b0;
    logic [2:0] rxd = 3'b111;
    logic [2:0] tready = 3'b111;
    logic [2:0] tvalid;
    logic [2:0] overrun;
    logic [7:0] tdata0, tdata1;
    logic [6:0] tdata2;
    logic [1:0] tuser0, tuser1, tuser2;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    axis_uart_rx u0 (
        .aclk(aclk), .arst(arst), .rxd(rxd[0]), .uart_ena(uart_ena),
        .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready[0]),
        .m_axis_tuser(tuser0), .overrun(overrun[0])
    );

    axis_uart_rx #(.PARITY_ENA(1), .PARITY_TYPE(0)) u1 (
        .aclk(aclk), .arst(arst), .rxd(rxd[1]), .uart_ena(uart_ena),
        .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready[1]),
        .m_axis_tuser(tuser1), .overrun(overrun[1])
    );

    axis_uart_rx #(.PARITY_ENA(1), .PARITY_TYPE(1), .STOP_BITS(2), .DATA_BITS(7),
                   .OVERSAMPLE(16)) u2 (
        .aclk(aclk), .arst(arst), .rxd(rxd[2]), .uart_ena(uart_ena),
        .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid[2]), .m_axis_tready(tready[2]),
        .m_axis_tuser(tuser2), .overrun(overrun[2])
    );

    // Tick generator: one pulse every ena_div cycles, changed away from the active edge.
    int ena_div = 4;
    int ena_cnt = 0;
    always @(negedge aclk) begin
        uart_ena = (ena_cnt == 0);
        ena_cnt  = (ena_cnt + 1 >= ena_div) ? 0 : ena_cnt + 1;
    end

    // Observer: records handshakes, tvalid rises and overrun pulses as the DUT sees them.
    logic       ena_prev = 1'b0;
    logic [2:0] tv_prev  = 3'b000;
    int rises[3], rise_bad[3], ovr[3], ovr_bad[3];
    logic [9:0] got0[$], got1[$], got2[$];

    always @(posedge aclk) begin
        if (!arst) begin
            for (int i = 0; i < 3; i++) begin
                if (tvalid[i] && !tv_prev[i]) begin
                    rises[i]++;
                    if (!ena_prev) rise_bad[i]++;
                end
                if (overrun[i]) begin
                    ovr[i]++;
                    if (!ena_prev) ovr_bad[i]++;
                end
            end
            if (tvalid[0] && tready[0]) got0.push_back({tuser0, tdata0});
            if (tvalid[1] && tready[1]) got1.push_back({tuser1, tdata1});
            if (tvalid[2] && tready[2]) got2.push_back({tuser2, 1'b0, tdata2});
        end
        tv_prev  = tvalid;
        ena_prev = uart_ena;
    end

    logic rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        do begin
            @(negedge aclk);
            if (rand_rdy) tready[2] = 1'($urandom_range(0, 1));
        end while (!ena_prev);
    endtask

    task automatic send_bit(input int w, input logic v);
        rxd[w] = v;
        repeat (16) wait_tick();
    endtask

    // par < 0 means no parity bit; otherwise bit 0 of par is placed on the line.
    task automatic send_frame(input int w, input logic [8:0] d, input int nb, input int par,
                              input int nstop, input logic stop_v);
        send_bit(w, 1'b0);
        for (int i = 0; i < nb; i++) send_bit(w, d[i]);
        if (par >= 0) send_bit(w, par[0]);
        for (int i = 0; i < nstop; i++) send_bit(w, stop_v);
    endtask

    function automatic int model_parity(input int ptype, input logic [8:0] d, input int nb);
        int ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(d[i]);
        case (ptype)
            1:       return (ones % 2 == 0) ? 1 : 0;
            2:       return 1;
            3:       return 0;
            default: return (ones % 2 == 1) ? 1 : 0;
        endcase
    endfunction

    task automatic pop_check(input int w, input string tag, input logic [9:0] exp);
        logic [9:0] v;
        v = 10'h3FF;
        case (w)
            0: if (got0.size() != 0) v = got0.pop_front();
            1: if (got1.size() != 0) v = got1.pop_front();
            default: if (got2.size() != 0) v = got2.pop_front();
        endcase
        check(tag, 32'(v), 32'(exp));
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    logic [9:0] exp2[$];

    initial begin
        int p;
        logic [8:0] d;

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_tvalid", 32'(tvalid), 0);
        check("rst_tdata0", 32'(tdata0), 0);
        check("rst_tuser0", 32'(tuser0), 0);
        check("rst_overrun", 32'(overrun), 0);
        arst = 1'b0;
        repeat (20) wait_tick();

        // 1: clean 8N1 character
        send_frame(0, 9'h0A5, 8, -1, 1, 1'b1);
        send_bit(0, 1'b1);
        check("t1_count", got0.size(), 1);
        pop_check(0, "t1_data", {2'b00, 8'hA5});
        check("t1_rises", rises[0], 1);
        check("t1_rise_timing", rise_bad[0], 0);
        check("t1_no_overrun", ovr[0], 0);

        // 2: even parity, correct then wrong parity bit
        p = model_parity(0, 9'h007, 8);
        send_frame(1, 9'h007, 8, p, 1, 1'b1);
        send_bit(1, 1'b1);
        send_frame(1, 9'h007, 8, 1 - p, 1, 1'b1);
        send_bit(1, 1'b1);
        check("t2_count", got1.size(), 2);
        pop_check(1, "t2_good_parity", {2'b00, 8'h07});
        pop_check(1, "t2_bad_parity", {2'b01, 8'h07});

        // 3: broken stop bit, then a line stuck low must not retrigger
        send_frame(0, 9'h03C, 8, -1, 1, 1'b0);
        repeat (30) send_bit(0, 1'b0);
        check("t3_count", got0.size(), 1);
        pop_check(0, "t3_frame_err", {2'b10, 8'h3C});
        send_bit(0, 1'b1);
        check("t3_no_retrigger", rises[0], 2);
        send_frame(0, 9'h081, 8, -1, 1, 1'b1);
        send_bit(0, 1'b1);
        pop_check(0, "t3_recover", {2'b00, 8'h81});

        // 4: short glitch is a false start
        rxd[0] = 1'b0;
        repeat (3) wait_tick();
        rxd[0] = 1'b1;
        repeat (32) wait_tick();
        check("t4_glitch_ignored", rises[0], 3);
        send_frame(0, 9'h055, 8, -1, 1, 1'b1);
        send_bit(0, 1'b1);
        pop_check(0, "t4_after_glitch", {2'b00, 8'h55});

        // 5: back-pressure and overrun
        tready[0] = 1'b0;
        send_frame(0, 9'h011, 8, -1, 1, 1'b1);
        send_bit(0, 1'b1);
        send_frame(0, 9'h022, 8, -1, 1, 1'b1);
        send_bit(0, 1'b1);
        check("t5_held_valid", 32'(tvalid[0]), 1);
        check("t5_held_data", 32'(tdata0), 32'h11);
        check("t5_overrun_pulses", ovr[0], 1);
        check("t5_overrun_timing", ovr_bad[0], 0);
        tready[0] = 1'b1;
        repeat (3) @(negedge aclk);
        pop_check(0, "t5_accept", {2'b00, 8'h11});
        check("t5_valid_low", 32'(tvalid[0]), 0);
        check("t5_no_extra", got0.size(), 0);

        // 6: randomized 7O2 stream with random back-pressure, fast ticks
        ena_div  = 1;
        rand_rdy = 1'b1;
        for (int k = 0; k < 256; k++) begin
            d = 9'($urandom_range(0, 127));
            exp2.push_back({2'b00, 1'b0, d[6:0]});
            send_frame(2, d, 7, model_parity(1, d, 7), 2, 1'b1);
        end
        rand_rdy  = 1'b0;
        tready[2] = 1'b1;
        repeat (4) @(negedge aclk);
        check("t6_count", got2.size(), 256);
        for (int k = 0; k < 256; k++) begin
            pop_check(2, $sformatf("t6_char%0d", k), exp2.pop_front());
        end
        check("t6_no_overrun", ovr[2], 0);

        // Reset mid-frame with a character buffered: nothing may come out
        tready[2] = 1'b0;
        send_frame(2, 9'h02A, 7, model_parity(1, 9'h02A, 7), 2, 1'b1);
        check("t6_buffered", 32'(tvalid[2]), 1);
        send_bit(2, 1'b0);
        send_bit(2, 1'b1);
        send_bit(2, 1'b0);
        arst = 1'b1;
        repeat (2) @(negedge aclk);
        arst      = 1'b0;
        rxd[2]    = 1'b1;
        tready[2] = 1'b1;
        repeat (12 * 16) wait_tick();
        check("t6_rst_valid", 32'(tvalid[2]), 0);
        check("t6_rst_nothing", got2.size(), 0);
        send_frame(2, 9'h05B, 7, model_parity(1, 9'h05B, 7), 2, 1'b1);
        send_bit(2, 1'b1);
        pop_check(2, "t6_after_rst", {2'b00, 1'b0, 7'h5B});
        check("rise_timing_all", rise_bad[0] + rise_bad[1] + rise_bad[2], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
